mc_ctrl_unit: RTL

MC_CTRL_UNIT -- requirements
Module: mc_ctrl_unit

---
 rtl/mc_ctrl_unit.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/mc_ctrl_unit.sv
// Multicycle controller for an ARM-subset datapath, including a handshaked multiplier.
// Ports: clk, reset (async, active-low); instruction fields Op/Funct/Rd/Cond/MulSig and ALUFlags/MulDone in;
//        datapath enables/selects, ALUControl, MulStart pulse and sticky MulErr out.
module mc_ctrl_unit #(
  parameter int ALUCTRL_W   = 3,
  parameter int MUL_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           Op,
  input  logic [5:0]           Funct,
  input  logic [3:0]           Rd,
  input  logic [3:0]           Cond,
  input  logic [3:0]           MulSig,
  input  logic [3:0]           ALUFlags,
  input  logic                 MulDone,
  output logic                 PCWrite,
  output logic                 RegWrite,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic                 AdrSrc,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ImmSrc,
  output logic [1:0]           RegSrc,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic                 MulStart,
  output logic                 MulErr
);

  localparam int CNT_W = $clog2(MUL_TIMEOUT + 1);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECUTER, EXECUTEI, MULSTART, MULWAIT, ALUWB, BRANCH
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] mul_cnt;
  logic [3:0]       flags;      // {N, Z, C, V}
  logic             mul_err;

  logic       next_pc, reg_w, mem_w, branch, alu_op, mul_alu, mul_timeout;
  logic [2:0] alu_ctl;
  logic [1:0] flag_w;
  logic       cond_ex, pcs;
  logic       is_mul;

  assign is_mul = (Funct[5:1] == 5'b00000) && (MulSig == 4'b1001);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= FETCH;
      mul_cnt <= '0;
      flags   <= 4'b0000;
      mul_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == MULSTART)
        mul_cnt <= '0;
      else if (state == MULWAIT)
        mul_cnt <= mul_cnt + CNT_W'(1);
      if (mul_timeout)
        mul_err <= 1'b1;
      if (flag_w[1] && cond_ex)
        flags[3:2] <= ALUFlags[3:2];
      if (flag_w[0] && cond_ex)
        flags[1:0] <= ALUFlags[1:0];
    end
  end

  always_comb begin
    state_nxt   = state;
    IRWrite     = 1'b0;
    AdrSrc      = 1'b0;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    ResultSrc   = 2'b00;
    next_pc     = 1'b0;
    reg_w       = 1'b0;
    mem_w       = 1'b0;
    branch      = 1'b0;
    alu_op      = 1'b0;
    mul_alu     = 1'b0;
    mul_timeout = 1'b0;
    MulStart    = 1'b0;
    case (state)
      FETCH: begin
        IRWrite   = 1'b1;
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        next_pc   = 1'b1;
        state_nxt = DECODE;
      end
      DECODE: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        case (Op)
          2'b01:   state_nxt = MEMADR;
          2'b10:   state_nxt = BRANCH;
          2'b00:   state_nxt = is_mul ? MULSTART : (Funct[5] ? EXECUTEI : EXECUTER);
          default: state_nxt = FETCH;
        endcase
      end
      MEMADR: begin
        ALUSrcB   = 2'b01;
        state_nxt = Funct[0] ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        AdrSrc    = 1'b1;
        state_nxt = MEMWB;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        reg_w     = 1'b1;
        state_nxt = FETCH;
      end
      MEMWRITE: begin
        AdrSrc    = 1'b1;
        mem_w     = 1'b1;
        state_nxt = FETCH;
      end
      EXECUTER: begin
        alu_op    = 1'b1;
        state_nxt = ALUWB;
      end
      EXECUTEI: begin
        ALUSrcB   = 2'b01;
        alu_op    = 1'b1;
        state_nxt = ALUWB;
      end
      MULSTART: begin
        MulStart  = 1'b1;
        state_nxt = MULWAIT;
      end
      MULWAIT: begin
        alu_op  = 1'b1;
        mul_alu = 1'b1;
        // A result arriving on the final allowed cycle still counts as success.
        if (MulDone)
          state_nxt = ALUWB;
        else if (mul_cnt == CNT_W'(MUL_TIMEOUT - 1)) begin
          mul_timeout = 1'b1;
          state_nxt   = FETCH;
        end
      end
      ALUWB: begin
        reg_w     = 1'b1;
        state_nxt = FETCH;
      end
      BRANCH: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        branch    = 1'b1;
        state_nxt = FETCH;
      end
      default: state_nxt = FETCH;
    endcase
  end

  // ALU decode; the multiply wait overrides the Funct decode and never writes flags.
  always_comb begin
    alu_ctl = 3'b000;
    flag_w  = 2'b00;
    if (mul_alu) begin
      alu_ctl = 3'b100;
    end else if (alu_op) begin
      case (Funct[4:1])
        4'b0100: alu_ctl = 3'b000;
        4'b0010: alu_ctl = 3'b001;
        4'b0000: alu_ctl = 3'b010;
        4'b1100: alu_ctl = 3'b011;
        default: alu_ctl = 3'b000;
      endcase
      flag_w[1] = Funct[0];
      flag_w[0] = Funct[0] && ((Funct[4:1] == 4'b0100) || (Funct[4:1] == 4'b0010));
    end
  end

  always_comb begin
    case (Cond)
      4'b0000: cond_ex = flags[2];
      4'b0001: cond_ex = !flags[2];
      4'b0010: cond_ex = flags[1];
      4'b0011: cond_ex = !flags[1];
      4'b0100: cond_ex = flags[3];
      4'b0101: cond_ex = !flags[3];
      4'b0110: cond_ex = flags[0];
      4'b0111: cond_ex = !flags[0];
      4'b1000: cond_ex = flags[1] && !flags[2];
      4'b1001: cond_ex = !flags[1] || flags[2];
      4'b1010: cond_ex = (flags[3] == flags[0]);
      4'b1011: cond_ex = (flags[3] != flags[0]);
      4'b1100: cond_ex = !flags[2] && (flags[3] == flags[0]);
      4'b1101: cond_ex = flags[2] || (flags[3] != flags[0]);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  assign pcs        = ((Rd == 4'hF) && reg_w) || branch;
  assign PCWrite    = next_pc || (pcs && cond_ex);
  assign RegWrite   = reg_w && cond_ex;
  assign MemWrite   = mem_w && cond_ex;
  assign ImmSrc     = Op;
  assign RegSrc     = {Op == 2'b01, Op == 2'b10};
  assign ALUControl = ALUCTRL_W'(alu_ctl);
  assign MulErr     = mul_err;

endmodule
